// File: rtl/game_flow_control.sv
// game_flow_control: main-screen game FSM handling score, lives, levels, pause,
// the timed ball-lost and level-up sequences, and game over.
module game_flow_control #(
    parameter int SCORE_WIDTH      = 16,
    parameter int LIFE_WIDTH       = 4,
    parameter int INIT_LIVES       = 3,
    parameter int MAX_LIVES        = 9,
    parameter int LEVELS           = 4,
    parameter int LEVEL_SCORE_STEP = 100,
    parameter int GOOD_POINTS      = 10,
    parameter int BAD_POINTS       = 5,
    parameter int LOST_FRAMES      = 60,
    parameter int LEVELUP_FRAMES   = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startOfFrame,
    input  logic                        start,
    input  logic                        pauseKey,
    input  logic                        collisionBallObstacleGood,
    input  logic                        collisionBallObstacleBad,
    input  logic                        collisionBallCredit,
    input  logic                        collisionBallBottom,
    output logic                        pause,
    output logic                        reset_level,
    output logic                        reset_level_pulse,
    output logic [SCORE_WIDTH-1:0]      score,
    output logic [LIFE_WIDTH-1:0]       life,
    output logic [$clog2(LEVELS)-1:0]   level,
    output logic                        gameOver
);
    localparam int LW = $clog2(LEVELS);
    localparam int SW = SCORE_WIDTH + 2;
    localparam int FW = $clog2((LOST_FRAMES > LEVELUP_FRAMES ? LOST_FRAMES : LEVELUP_FRAMES) + 1);

    typedef enum logic [2:0] {IDLE, PLAY, PAUSED, LOST, LEVELUP, OVER} state_t;
    state_t state, nextState;

    logic [6:0] inRaw, inPrev, inEdge;
    logic evFrame, evStart, evPause, evGood, evBad, evCredit, evBottom;
    logic [FW-1:0] frameCnt, frameNext;
    logic [SCORE_WIDTH-1:0] scoreNext;
    logic [LIFE_WIDTH-1:0] lifeNext;
    logic [LW-1:0] levelNext;
    logic pulseNext, levelUpDue;
    logic signed [SW-1:0] mult, delta, sum;

    assign inRaw = {startOfFrame, start, pauseKey, collisionBallObstacleGood,
                    collisionBallObstacleBad, collisionBallCredit, collisionBallBottom};
    assign {evFrame, evStart, evPause, evGood, evBad, evCredit, evBottom} = inEdge;

    always_comb begin
        nextState  = state;
        scoreNext  = score;
        lifeNext   = life;
        levelNext  = level;
        pulseNext  = 1'b0;
        frameNext  = (evFrame && (state == LOST || state == LEVELUP)) ? frameCnt + FW'(1) : frameCnt;
        mult       = SW'({1'b0, level}) + SW'(1);
        delta      = (evGood ? SW'(GOOD_POINTS) * mult : '0) - (evBad ? SW'(BAD_POINTS) * mult : '0);
        sum        = $signed({2'b00, score}) + delta;
        levelUpDue = 32'(score) >= (32'(level) + 1) * LEVEL_SCORE_STEP && 32'(level) < LEVELS - 1;
        case (state)
            IDLE, OVER: if (evStart) begin
                nextState = PLAY;
                scoreNext = '0;
                lifeNext  = LIFE_WIDTH'(INIT_LIVES);
                levelNext = '0;
                pulseNext = 1'b1;
            end
            PLAY: if (evBottom) begin
                lifeNext  = (life == '0) ? life : life - LIFE_WIDTH'(1);
                nextState = LOST;
            end else begin
                // sign bit means underflow, bit SCORE_WIDTH means overflow
                scoreNext = sum[SW-1] ? '0 : sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];
                if (evCredit && life < LIFE_WIDTH'(MAX_LIVES)) lifeNext = life + LIFE_WIDTH'(1);
                if (evPause) nextState = PAUSED;
                else if (levelUpDue) nextState = LEVELUP;
            end
            PAUSED: if (evPause) nextState = PLAY;
            LOST: if (evFrame && frameCnt == FW'(LOST_FRAMES - 1)) begin
                nextState = (life == '0) ? OVER : PLAY;
                pulseNext = life != '0;
            end
            LEVELUP: if (evFrame && frameCnt == FW'(LEVELUP_FRAMES - 1)) begin
                nextState = PLAY;
                levelNext = level + LW'(1);
                pulseNext = 1'b1;
            end
            default: nextState = IDLE;
        endcase
        if (nextState != state) frameNext = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            inPrev            <= '0;
            inEdge            <= '0;
            frameCnt          <= '0;
            score             <= '0;
            life              <= LIFE_WIDTH'(INIT_LIVES);
            level             <= '0;
            reset_level_pulse <= 1'b0;
            pause             <= 1'b1;
            reset_level       <= 1'b1;
            gameOver          <= 1'b0;
        end else begin
            state             <= nextState;
            inPrev            <= inRaw;
            inEdge            <= inRaw & ~inPrev;
            frameCnt          <= frameNext;
            score             <= scoreNext;
            life              <= lifeNext;
            level             <= levelNext;
            reset_level_pulse <= pulseNext;
            pause             <= nextState != PLAY;
            reset_level       <= !(nextState == PLAY || nextState == PAUSED);
            gameOver          <= nextState == OVER;
        end
    end
endmodule

// File: doc/game_flow_control.md
# game_flow_control

Parametrised main-screen game controller for the pinball design. It is the successor to the fixed screen-main control logic: configurable score and life widths, a multi-level progression with a per-level score multiplier, a timed ball-lost sequence, a user pause toggle and a game-over state. It sits inside the main screen between the collision detector and the ball, flipper, spring and trap blocks, which consume `pause`, `reset_level` and `reset_level_pulse`. The indications block displays `score`, `life` and `level`.

## Interface
Parameters:
- `SCORE_WIDTH`, 16, width of `score`; score saturates at 2^SCORE_WIDTH-1.
- `LIFE_WIDTH`, 4, width of `life`.
- `INIT_LIVES`, 3, lives loaded at game start.
- `MAX_LIVES`, 9, saturation limit for credit-awarded lives (≤ 2^LIFE_WIDTH-1).
- `LEVELS`, 4, number of levels (level index 0..LEVELS-1).
- `LEVEL_SCORE_STEP`, 100, level k+1 is reached when score ≥ (k+1)*LEVEL_SCORE_STEP.
- `GOOD_POINTS`, 10, base points per good-obstacle hit.
- `BAD_POINTS`, 5, base points removed per bad-obstacle hit.
- `LOST_FRAMES`, 60, frames held in LOST.
- `LEVELUP_FRAMES`, 30, frames held in LEVELUP.

Ports:
- `clk` in 1: system clock (pixel clock domain).
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `start` in 1: start/restart request (level).
- `pauseKey` in 1: pause toggle key (level).
- `collisionBallObstacleGood` in 1: ball hit a good obstacle (level).
- `collisionBallObstacleBad` in 1: ball hit a bad obstacle (level).
- `collisionBallCredit` in 1: ball hit a credit (level).
- `collisionBallBottom` in 1: ball reached the bottom (level).
- `pause` out 1: freeze all moving objects.
- `reset_level` out 1: hold objects at their level start positions.
- `reset_level_pulse` out 1: one-cycle pulse when a level (re)starts.
- `score` out SCORE_WIDTH: current score.
- `life` out LIFE_WIDTH: remaining lives.
- `level` out $clog2(LEVELS): current level index.
- `gameOver` out 1: high in OVER.

## Operation
- All inputs are rising-edge detected with one register stage. Only edges count as events.
- FSM states: IDLE, PLAY, PAUSED, LOST, LEVELUP, OVER.
- IDLE: `pause`=1, `reset_level`=1. A `start` edge clears score to 0, loads `life`=INIT_LIVES and `level`=0, pulses `reset_level_pulse`, and moves to PLAY.
- PLAY: `pause`=0, `reset_level`=0. Per cycle, events are resolved in this priority order:
  - A bottom event decrements `life` (floor 0) and moves to LOST. Every other event in that same cycle is discarded.
  - A `pauseKey` edge moves to PAUSED. Any obstacle or credit events in that same cycle are still applied.
  - Score delta = good*GOOD_POINTS*(level+1) − bad*BAD_POINTS*(level+1). Good and bad in the same cycle are netted. The delta is computed at SCORE_WIDTH+2 signed width, and the result saturates to the range [0, 2^SCORE_WIDTH-1].
  - A credit event increments `life`, saturating at MAX_LIVES.
- Level check: in PLAY, when the registered score ≥ (level+1)*LEVEL_SCORE_STEP and level < LEVELS-1, the FSM moves to LEVELUP. At the last level the level check is disabled.
- PAUSED: `pause`=1, `reset_level`=0. All events are ignored. A `pauseKey` edge returns to PLAY.
- LOST: `pause`=1, `reset_level`=1. The state counts `startOfFrame` pulses. When the count reaches LOST_FRAMES:
  - If `life`=0, go to OVER.
  - Otherwise pulse `reset_level_pulse` and go to PLAY.
- LEVELUP: `pause`=1, `reset_level`=1. The state counts LEVELUP_FRAMES frames, then increments `level`, pulses `reset_level_pulse` and goes to PLAY.
- OVER: `pause`=1, `reset_level`=1, `gameOver`=1. `score` and `level` hold their values. A `start` edge restarts the game exactly as from IDLE.
- The frame counter clears on every state entry.

## Timing
- Reset values: state=IDLE, `pause`=1, `reset_level`=1, `reset_level_pulse`=0, `score`=0, `life`=INIT_LIVES, `level`=0, `gameOver`=0, frame counter=0, edge registers=0.
- All outputs are registered.
- Latency from a raw input change to the corresponding output update is 2 cycles: edge detect, then state/score register.
- `reset_level_pulse` is exactly 1 cycle wide and is coincident with the first cycle of PLAY.
- The level check uses the registered score, so LEVELUP is entered 1 cycle after the score crosses the threshold.
- An input held high produces exactly one event. A new event requires the input to go low and high again.
- An asserted `reset` overrides every state, including an in-progress LOST or LEVELUP count, and produces the reset values on the next edge.

## Test plan
- Reset, then a `start` edge: `reset_level_pulse` is high for 1 cycle, state=PLAY, `life`=3, `score`=0, `pause`=0.
- In PLAY at level 0, 3 good edges and 1 bad edge: `score`=25. Then 1 cycle with good and bad simultaneously: `score`=30. A bad edge with `score`=0: `score` stays 0.
- Score reaches 100: enters LEVELUP with `pause`=1. After 30 `startOfFrame` pulses: `level`=1, `reset_level_pulse`=1, state=PLAY. The next good edge adds 20.
- Bottom edge coincident with a credit edge at `life`=1: `life`=0 (credit ignored), LOST for 60 frames, then OVER with `gameOver`=1. A `start` edge restarts with `score`=0 and `life`=3.
- With `life`=9, a credit edge keeps `life`=9. A `pauseKey` edge enters PAUSED, where a good edge leaves `score` unchanged. A second `pauseKey` edge returns to PLAY.
- Assert `reset` at frame 20 of LOST: on the next edge all outputs return to their reset values and state=IDLE.
